// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, opcodes, funct codes and decode helpers for the 5-stage core
package pipeline_pkg;
    localparam int XLEN = 16;
    localparam int PCW = 8;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW = 4'h3;
    localparam logic [3:0] OP_SW = 4'h4;
    localparam logic [3:0] OP_BEQ = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_SLT = 3'd5;
    localparam logic [2:0] F_SLL = 3'd6;
    localparam logic [2:0] F_SRL = 3'd7;

    function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
        return {{(XLEN-6){v[5]}}, v};
    endfunction

    function automatic logic writes_rd(input logic [15:0] ir);
        return (ir[15:12] == OP_ALU || ir[15:12] == OP_ADDI || ir[15:12] == OP_LW) && ir[11:9] != 3'd0;
    endfunction

    function automatic logic uses_rs(input logic [15:0] ir);
        return ir[15:12] inside {OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
    endfunction

    function automatic logic uses_rt(input logic [15:0] ir);
        return ir[15:12] == OP_ALU;
    endfunction

    function automatic logic uses_rd(input logic [15:0] ir);
        return ir[15:12] == OP_SW || ir[15:12] == OP_BEQ;
    endfunction
endpackage

// File: rtl/pipeline_top_mem.sv
// pipeline_top_mem: instruction store, register file and data store used by pipeline_top
module icache import pipeline_pkg::*; #(
    parameter int DEPTH = 256
) (
    input logic clk,
    input logic we,
    input logic [PCW-1:0] waddr,
    input logic [XLEN-1:0] wdata,
    input logic [PCW-1:0] addr,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] mem [0:DEPTH-1];

    // image patch port; never reset so a preloaded program survives reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[addr];
endmodule

module regfile import pipeline_pkg::*; (
    input logic clk,
    input logic rst,
    input logic we,
    input logic [RW-1:0] wa,
    input logic [XLEN-1:0] wd,
    input logic [RW-1:0] ra,
    input logic [RW-1:0] rb,
    input logic [RW-1:0] rc,
    output logic [XLEN-1:0] qa,
    output logic [XLEN-1:0] qb,
    output logic [XLEN-1:0] qc
);
    logic [XLEN-1:0] regs [0:7];

    // r0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < 8; i++) regs[i] <= '0;
        else if (we && wa != '0) regs[wa] <= wd;

    assign qa = ra == '0 ? '0 : (we && wa == ra) ? wd : regs[ra];
    assign qb = rb == '0 ? '0 : (we && wa == rb) ? wd : regs[rb];
    assign qc = rc == '0 ? '0 : (we && wa == rc) ? wd : regs[rc];
endmodule

module dcache import pipeline_pkg::*; #(
    parameter int DEPTH = 256
) (
    input logic clk,
    input logic rst,
    input logic we,
    input logic [AW-1:0] addr,
    input logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] mem [0:DEPTH-1];

    // whole array clears on reset; store on the clock edge in MEM
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/pipeline_top.sv
// pipeline_top: 5-stage in-order core with forwarding, load-use stall, EX-resolved branches and sticky halt
module pipeline_top import pipeline_pkg::*; #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int XLEN = 16
) (
    input logic clk,
    input logic rst_n
);
    logic [PCW-1:0] pc, ifid_pc, idex_pc, ex_target;
    logic [XLEN-1:0] instr, ifid_ir, idex_ir, idex_a, idex_b, idex_c;
    logic [XLEN-1:0] rf_a, rf_b, rf_c, ex_a, ex_b, ex_c, ex_imm, ex_alu, ex_res;
    logic [XLEN-1:0] exmem_res, exmem_sd, memwb_val, dmem_q;
    logic [RW-1:0] id_rd, id_rs, id_rt, ex_rd, ex_rs, ex_rt, exmem_rd, memwb_rd;
    logic [3:0] ex_op;
    logic [2:0] ex_f;
    logic halted, halt_now, stall, flush;
    logic exmem_wr, exmem_ld, exmem_st, memwb_wr;

    icache #(.DEPTH(IMEM_DEPTH)) INSTRUCTION_CACHE (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .addr(pc), .rdata(instr)
    );

    regfile REG_FILE (
        .clk(clk), .rst(rst_n), .we(memwb_wr), .wa(memwb_rd), .wd(memwb_val),
        .ra(id_rs), .rb(id_rt), .rc(id_rd), .qa(rf_a), .qb(rf_b), .qc(rf_c)
    );

    dcache #(.DEPTH(DMEM_DEPTH)) DATA_CACHE (
        .clk(clk), .rst(rst_n), .we(exmem_st), .addr(exmem_res[AW-1:0]), .wdata(exmem_sd), .rdata(dmem_q)
    );

    assign id_rd = ifid_ir[11:9];
    assign id_rs = ifid_ir[8:6];
    assign id_rt = ifid_ir[5:3];
    assign ex_op = idex_ir[15:12];
    assign ex_rd = idex_ir[11:9];
    assign ex_rs = idex_ir[8:6];
    assign ex_rt = idex_ir[5:3];
    assign ex_f = idex_ir[2:0];
    assign ex_imm = sext6(idex_ir[5:0]);

    // writers never target r0, so a matching index implies a non-r0 source
    assign ex_a = (exmem_wr && exmem_rd == ex_rs) ? exmem_res : (memwb_wr && memwb_rd == ex_rs) ? memwb_val : idex_a;
    assign ex_b = (exmem_wr && exmem_rd == ex_rt) ? exmem_res : (memwb_wr && memwb_rd == ex_rt) ? memwb_val : idex_b;
    assign ex_c = (exmem_wr && exmem_rd == ex_rd) ? exmem_res : (memwb_wr && memwb_rd == ex_rd) ? memwb_val : idex_c;

    // ALU result selected by funct
    always_comb begin
        ex_alu = ex_a + ex_b;
        case (ex_f)
            F_SUB: ex_alu = ex_a - ex_b;
            F_AND: ex_alu = ex_a & ex_b;
            F_OR: ex_alu = ex_a | ex_b;
            F_XOR: ex_alu = ex_a ^ ex_b;
            F_SLT: ex_alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
            F_SLL: ex_alu = ex_a << ex_b[3:0];
            F_SRL: ex_alu = ex_a >> ex_b[3:0];
            default: ;
        endcase
    end

    assign ex_res = ex_op == OP_ALU ? ex_alu : ex_a + ex_imm;
    assign ex_target = ex_op == OP_JMP ? idex_ir[7:0] : idex_pc + PCW'(1) + ex_imm[PCW-1:0];
    assign flush = (ex_op == OP_BEQ && ex_c == ex_a) || ex_op == OP_JMP;
    assign stall = ex_op == OP_LW && writes_rd(idex_ir) &&
        ((uses_rs(ifid_ir) && id_rs == ex_rd) || (uses_rt(ifid_ir) && id_rt == ex_rd) || (uses_rd(ifid_ir) && id_rd == ex_rd));
    assign halt_now = ifid_ir[15:12] == OP_HALT && !flush;

    // fetch and IF/ID: flush beats stall, halt freezes PC and feeds NOPs
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            pc <= '0;
            ifid_ir <= NOP;
            ifid_pc <= '0;
            halted <= 1'b0;
        end else begin
            halted <= halted | halt_now;
            pc <= flush ? ex_target : (stall || halted || halt_now) ? pc : pc + PCW'(1);
            if (flush || halted || halt_now) ifid_ir <= NOP;
            else if (!stall) begin
                ifid_ir <= instr;
                ifid_pc <= pc;
            end
        end

    // ID/EX: bubble on flush or load-use stall
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            idex_ir <= NOP;
            idex_pc <= '0;
            idex_a <= '0;
            idex_b <= '0;
            idex_c <= '0;
        end else begin
            idex_ir <= (flush || stall) ? NOP : ifid_ir;
            idex_pc <= ifid_pc;
            idex_a <= rf_a;
            idex_b <= rf_b;
            idex_c <= rf_c;
        end

    // EX/MEM and MEM/WB: carry results and write enables toward writeback
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            exmem_wr <= 1'b0;
            exmem_ld <= 1'b0;
            exmem_st <= 1'b0;
            exmem_rd <= '0;
            exmem_res <= '0;
            exmem_sd <= '0;
            memwb_wr <= 1'b0;
            memwb_rd <= '0;
            memwb_val <= '0;
        end else begin
            exmem_wr <= writes_rd(idex_ir);
            exmem_ld <= ex_op == OP_LW;
            exmem_st <= ex_op == OP_SW;
            exmem_rd <= ex_rd;
            exmem_res <= ex_res;
            exmem_sd <= ex_c;
            memwb_wr <= exmem_wr;
            memwb_rd <= exmem_rd;
            memwb_val <= exmem_ld ? dmem_q : exmem_res;
        end
endmodule

// File: tb/tb_pipeline_top.sv
// tb_pipeline_top: directed programs with a scoreboard of expected register/memory results
module tb_pipeline_top;
    import pipeline_pkg::*;

    typedef struct {
        int kind;
        int idx;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [15:0] prog[$];
    logic [15:0] er [8];
    localparam logic [15:0] HLT = 16'hF000;

    pipeline_top dut (.clk(clk), .rst_n(rst_n));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ri(input logic [3:0] op, input int rd, input int rs, input int imm);
        return {op, 3'(rd), 3'(rs), 6'(imm)};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] f, input int rd, input int rs, input int rt);
        return {OP_ALU, 3'(rd), 3'(rs), 3'(rt), f};
    endfunction

    function automatic logic [15:0] jmp(input int t);
        return {OP_JMP, 12'(t)};
    endfunction

    task automatic clr();
        foreach (er[i]) er[i] = '0;
    endtask

    task automatic push_regs();
        for (int i = 0; i < 8; i++) sb.push_back('{0, i, er[i]});
    endtask

    task automatic push_mem(input int a, input logic [15:0] v);
        sb.push_back('{1, a, v});
    endtask

    task automatic start();
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.INSTRUCTION_CACHE.mem[i] = (i < prog.size()) ? prog[i] : 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic run(input string name, output int stalls);
        int n;
        n = 0;
        stalls = 0;
        start();
        while (!dut.halted && n < 400) begin
            @(negedge clk);
            if (dut.stall) stalls++;
            n++;
        end
        chk({name, "/halted"}, 32'(dut.halted), 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s/%s%0d", name, e.kind != 0 ? "dmem" : "r", e.idx),
                e.kind != 0 ? dut.DATA_CACHE.mem[e.idx] : dut.REG_FILE.regs[e.idx], e.val);
        end
    endtask

    initial begin
        int st;
        #1 rst_n = 1'b1;
        #20;
        chk("rst/pc", dut.pc, 0);
        chk("rst/halted", 32'(dut.halted), 0);
        chk("rst/ifid", dut.ifid_ir, 0);
        chk("rst/idex", dut.idex_ir, 0);
        chk("rst/exmem_wr", 32'(dut.exmem_wr), 0);
        chk("rst/exmem_st", 32'(dut.exmem_st), 0);
        chk("rst/memwb_wr", 32'(dut.memwb_wr), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst/r%0d", i), dut.REG_FILE.regs[i], 0);
        chk("rst/dmem0", dut.DATA_CACHE.mem[0], 0);
        chk("rst/dmem255", dut.DATA_CACHE.mem[255], 0);

        prog = '{ri(OP_ADDI, 1, 0, 5), ri(OP_ADDI, 2, 0, -3), rr(F_ADD, 3, 1, 2), HLT};
        clr(); er[1] = 16'h0005; er[2] = 16'hFFFD; er[3] = 16'h0002; push_regs();
        run("indep", st); chk("indep/stalls", st, 0); drain("indep");

        prog = '{ri(OP_ADDI, 1, 0, 7), ri(OP_ADDI, 1, 1, 1), rr(F_SLL, 2, 1, 1), HLT};
        clr(); er[1] = 16'h0008; er[2] = 16'h0800; push_regs();
        run("dep", st); chk("dep/stalls", st, 0); drain("dep");

        prog = '{ri(OP_ADDI, 1, 0, 9), ri(OP_SW, 1, 0, 4), ri(OP_LW, 2, 0, 4), ri(OP_ADDI, 3, 2, 1), HLT};
        clr(); er[1] = 16'h0009; er[2] = 16'h0009; er[3] = 16'h000A; push_regs(); push_mem(4, 16'h0009);
        run("ldu", st); chk("ldu/stalls", st, 1); drain("ldu");

        prog = '{ri(OP_ADDI, 1, 0, 1), ri(OP_BEQ, 1, 1, 2), ri(OP_ADDI, 4, 0, 1), ri(OP_ADDI, 4, 0, 2),
                 ri(OP_ADDI, 5, 0, 3), HLT};
        clr(); er[1] = 16'h0001; er[5] = 16'h0003; push_regs();
        run("br", st); chk("br/stalls", st, 0); drain("br");

        prog = '{ri(OP_ADDI, 1, 0, -6), ri(OP_ADDI, 2, 0, 3), rr(F_SUB, 3, 1, 2), rr(F_AND, 4, 1, 2),
                 rr(F_OR, 5, 1, 2), rr(F_XOR, 6, 1, 2), rr(F_SLT, 7, 1, 2), rr(F_SRL, 3, 1, 2),
                 rr(F_SLT, 4, 2, 1), HLT};
        clr(); er[1] = 16'hFFFA; er[2] = 16'h0003; er[3] = 16'h1FFF; er[4] = 16'h0000;
        er[5] = 16'hFFFB; er[6] = 16'hFFF9; er[7] = 16'h0001; push_regs();
        run("alu", st); chk("alu/stalls", st, 0); drain("alu");

        prog = '{ri(OP_ADDI, 0, 0, 5), HLT, ri(OP_ADDI, 6, 0, 1)};
        clr(); push_regs();
        run("r0halt", st); drain("r0halt");
        chk("r0halt/pc", dut.pc, 2);
        repeat (5) @(negedge clk);
        chk("r0halt/pc_hold", dut.pc, 2);
        chk("r0halt/still_halted", 32'(dut.halted), 1);

        prog = '{ri(OP_ADDI, 1, 0, 5), ri(OP_ADDI, 2, 2, 3), ri(OP_SW, 2, 0, 1), ri(OP_ADDI, 1, 1, -1),
                 ri(OP_BEQ, 1, 0, 1), jmp(1), HLT};
        clr(); er[2] = 16'h000F; push_regs(); push_mem(1, 16'h000F);
        run("loop", st); chk("loop/stalls", st, 0); drain("loop");

        start();
        repeat (12) @(negedge clk);
        chk("midrst/r2_live", 32'(dut.REG_FILE.regs[2] != 0), 1);
        chk("midrst/dmem1_live", 32'(dut.DATA_CACHE.mem[1] != 0), 1);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst/pc", dut.pc, 0);
        chk("midrst/halted", 32'(dut.halted), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("midrst/r%0d", i), dut.REG_FILE.regs[i], 0);
        chk("midrst/dmem1", dut.DATA_CACHE.mem[1], 0);
        clr(); er[2] = 16'h000F; push_regs(); push_mem(1, 16'h000F);
        run("rerun", st); chk("rerun/stalls", st, 0); drain("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
